// File: rtl/iiitb_riscv_mem_arb.sv
// Arbiter/sequencer sharing one single-port unified memory between the fetch port and the
// load/store port. Data port has priority; a starvation counter forces fetch progress.
//
// state | meaning
// IDLE  | no access in flight; arbitrate and latch the winner's request
// ISSUE | memory strobe cycle; winner's grant pulses
// WAIT  | read in flight; down-count the memory latency, then return data
module iiitb_riscv_mem_arb #(
    parameter int AW         = 5,
    parameter int DW         = 32,
    parameter int LAT        = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [2:0] LAT_INIT   = 3'(LAT);

    state_t     state;
    logic       owner_dm;
    logic [2:0] wait_cnt;
    logic [3:0] starve_cnt;
    logic       pick_if;
    logic       pick_dm;

    // Fetch only beats a pending data request once the data port has used up its allowance.
    assign pick_if = if_req && (!dm_req || (starve_cnt == STARVE_LIM));
    assign pick_dm = dm_req && !pick_if;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner_dm   <= 1'b0;
            wait_cnt   <= '0;
            starve_cnt <= '0;
            if_gnt     <= 1'b0;
            if_rvalid  <= 1'b0;
            if_rdata   <= '0;
            dm_gnt     <= 1'b0;
            dm_rvalid  <= 1'b0;
            dm_rdata   <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            if_gnt    <= 1'b0;
            dm_gnt    <= 1'b0;
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_if) begin
                        state      <= ISSUE;
                        owner_dm   <= 1'b0;
                        mem_en     <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= if_addr;
                        if_gnt     <= 1'b1;
                        starve_cnt <= '0;
                    end else if (pick_dm) begin
                        state     <= ISSUE;
                        owner_dm  <= 1'b1;
                        mem_en    <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        dm_gnt    <= 1'b1;
                        if (!if_req) begin
                            starve_cnt <= '0;
                        end else if (starve_cnt != STARVE_LIM) begin
                            starve_cnt <= starve_cnt + 4'd1;
                        end
                    end else begin
                        starve_cnt <= '0;
                    end
                end
                ISSUE: begin
                    if (mem_we) begin
                        state <= IDLE;
                    end else begin
                        state    <= WAIT;
                        wait_cnt <= LAT_INIT;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 3'd1;
                    if (wait_cnt == 3'd1) begin
                        state <= IDLE;
                        if (owner_dm) begin
                            dm_rdata  <= mem_rdata;
                            dm_rvalid <= 1'b1;
                        end else begin
                            if_rdata  <= mem_rdata;
                            if_rvalid <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iiitb_riscv_mem_arb.sv
// Directed bench for iiitb_riscv_mem_arb with a behavioural latency-LAT memory model.
module tb_iiitb_riscv_mem_arb;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int LAT = 2;
    localparam int STARVE_MAX = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_gnt;
    logic          dm_rvalid;
    logic [DW-1:0] dm_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    iiitb_riscv_mem_arb #(
        .AW(AW), .DW(DW), .LAT(LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory model: word a holds 0x1000_0000+a (word 3 holds 0x13); read data appears LAT
    // cycles after the strobe, and a poison value otherwise so early/late capture shows.
    logic [DW-1:0] mem [32];
    logic [DW-1:0] pipe [LAT];
    logic          init_done = 1'b0;

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 32; i++) mem[i] <= (i == 3) ? 32'h0000_0013 : 32'h1000_0000 + i;
            init_done <= 1'b1;
        end else if (mem_en && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr] : 32'hBADB_AD00;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata = pipe[LAT-1];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_strb"}, {20'd0, if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_en, mem_we,
                             busy, mem_addr}, 32'd0);
        chk({tag, "_ifrd"}, if_rdata, 32'd0);
        chk({tag, "_dmrd"}, dm_rdata, 32'd0);
        chk({tag, "_wdat"}, mem_wdata, 32'd0);
    endtask

    logic [9:0] seq;
    int         ngnt;
    logic       saw;

    initial begin
        rst_n = 1'b0; if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        #2;
        chk_all_zero("rst");
        step(); step();
        @(negedge clk); rst_n = 1'b1;
        step();
        chk("rst_idle_busy", busy, 1'b0);

        // Fetch read of word 3
        if_req = 1'b1; if_addr = 5'd3;
        step();
        chk("f_gnt", if_gnt, 1'b1);
        chk("f_en", mem_en, 1'b1);
        chk("f_addr", mem_addr, 32'd3);
        chk("f_we", mem_we, 1'b0);
        chk("f_dgnt", dm_gnt, 1'b0);
        if_req = 1'b0; if_addr = '0;
        step();
        chk("f_c2_en", mem_en, 1'b0);
        chk("f_c2_gnt", if_gnt, 1'b0);
        step();
        chk("f_c3_rv", if_rvalid, 1'b0);
        chk("f_c3_busy", busy, 1'b1);
        step();
        chk("f_c4_rv", if_rvalid, 1'b1);
        chk("f_c4_rd", if_rdata, 32'h0000_0013);
        chk("f_c4_busy", busy, 1'b0);
        chk("f_c4_dmrd", dm_rdata, 32'd0);
        step();
        chk("f_c5_rv", if_rvalid, 1'b0);
        chk("f_c5_hold", if_rdata, 32'h0000_0013);

        // Data write of 0xDEADBEEF to word 5
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 5'd5; dm_wdata = 32'hDEAD_BEEF;
        step();
        chk("w_gnt", dm_gnt, 1'b1);
        chk("w_en_we", {mem_en, mem_we}, 2'b11);
        chk("w_addr", mem_addr, 32'd5);
        chk("w_data", mem_wdata, 32'hDEAD_BEEF);
        chk("w_igt", if_gnt, 1'b0);
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        step();
        chk("w_c2_en", {mem_en, mem_we, dm_gnt}, 3'b000);
        chk("w_c2_busy", busy, 1'b0);
        saw = dm_rvalid;
        for (int i = 0; i < 4; i++) begin
            step();
            saw = saw | dm_rvalid | mem_en;
        end
        chk("w_no_rv", saw, 1'b0);

        // Read word 5 back over the data port
        dm_req = 1'b1; dm_addr = 5'd5;
        step();
        chk("rb_gnt", dm_gnt, 1'b1);
        dm_req = 1'b0; dm_addr = '0;
        step(); step(); step();
        chk("rb_rv", dm_rvalid, 1'b1);
        chk("rb_rd", dm_rdata, 32'hDEAD_BEEF);
        step();

        // Simultaneous requests: data first, fetch after
        if_req = 1'b1; if_addr = 5'd1;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 5'd2;
        for (int c = 1; c <= 9; c++) begin
            step();
            if (c == 1) begin
                chk("s_c1_gnt", {if_gnt, dm_gnt}, 2'b01);
                chk("s_c1_addr", mem_addr, 32'd2);
            end
            if (c == 4) begin
                chk("s_c4_rv", {if_rvalid, dm_rvalid}, 2'b01);
                chk("s_c4_drd", dm_rdata, 32'h1000_0002);
                chk("s_c4_ird", if_rdata, 32'h0000_0013);
            end
            if (c == 5) begin
                chk("s_c5_gnt", {if_gnt, dm_gnt}, 2'b10);
                chk("s_c5_addr", mem_addr, 32'd1);
            end
            if (c == 8) begin
                chk("s_c8_rv", {if_rvalid, dm_rvalid}, 2'b10);
                chk("s_c8_ird", if_rdata, 32'h1000_0001);
                chk("s_c8_drd", dm_rdata, 32'h1000_0002);
            end
            if (dm_gnt) dm_req = 1'b0;
            if (if_gnt) if_req = 1'b0;
        end
        if_addr = '0; dm_addr = '0;

        // Starvation: fetch held, data writes every idle cycle -> D D D D I D D D D I
        seq = '0; ngnt = 0;
        if_req = 1'b1; if_addr = 5'd4;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 5'd10; dm_wdata = 32'h0000_5A5A;
        for (int c = 0; c < 100 && ngnt < 10; c++) begin
            step();
            if (dm_gnt || if_gnt) begin
                seq = {seq[8:0], dm_gnt};
                ngnt++;
            end
        end
        chk("st_ngnt", ngnt, 32'd10);
        chk("st_seq", seq, 10'b11110_11110);
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; if_addr = '0;
        for (int c = 0; c < 10 && busy; c++) step();
        step();
        chk("st_idle", busy, 1'b0);

        // Reset during WAIT aborts the read
        if_req = 1'b1; if_addr = 5'd7;
        step();
        chk("r_gnt", if_gnt, 1'b1);
        if_req = 1'b0; if_addr = '0;
        step();
        chk("r_wait_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("r_async");
        saw = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            saw = saw | if_rvalid | dm_rvalid | busy;
        end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            saw = saw | if_rvalid | dm_rvalid | busy;
        end
        chk("r_no_rv", saw, 1'b0);

        if_req = 1'b1; if_addr = 5'd9;
        step();
        chk("r2_gnt", if_gnt, 1'b1);
        if_req = 1'b0; if_addr = '0;
        step(); step(); step();
        chk("r2_rv", if_rvalid, 1'b1);
        chk("r2_rd", if_rdata, 32'h1000_0009);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog sim time exceeded");
        $fatal(1);
    end

endmodule
